// File: rtl/util_pulse_seq.sv
// Trigger scheduler and configuration sequencer for a bank of pulse-delay channels.
// Generates the periodic broadcast trigger and applies shadow config only at safe points.
module util_pulse_seq #(
  parameter int unsigned CH_NUM         = 4,
  parameter logic [31:0] DEFAULT_PERIOD = 32'd1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic [31:0]           cfg_period,
  input  logic [31:0]           cfg_count,
  input  logic                  wr_en,
  input  logic [7:0]            wr_ch,
  input  logic [1:0]            wr_type,
  input  logic [31:0]           wr_hold,
  input  logic [31:0]           wr_delay,
  input  logic                  commit,
  output logic                  commit_pend,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           trig_cnt,
  output logic                  miss,
  input  logic [CH_NUM-1:0]     ch_ready,
  output logic [CH_NUM-1:0]     ch_en,
  output logic                  ch_trig,
  output logic                  ch_cfg_update,
  output logic [2*CH_NUM-1:0]   ch_cfg_type,
  output logic [32*CH_NUM-1:0]  ch_cfg_hold,
  output logic [32*CH_NUM-1:0]  ch_cfg_delay
);

  localparam int unsigned CW = 32;
  localparam int unsigned TW = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_UPD_COPY,
    S_UPD_STRB,
    S_DRAIN
  } state_t;

  typedef struct packed {
    logic [TW-1:0] typ;
    logic [CW-1:0] hold;
    logic [CW-1:0] delay;
  } cfg_t;

  localparam cfg_t CFG_RST = '{typ: TW'(0), hold: CW'(1), delay: CW'(0)};

  // Periods below 2 would collide the reload with the trigger cycle.
  function automatic logic [CW-1:0] clamp_period(input logic [CW-1:0] p);
    return (p < CW'(2)) ? CW'(2) : p;
  endfunction

  state_t          state_q,    state_nxt;
  logic [CW-1:0]   per_cnt_q,  per_cnt_nxt;
  logic [CW-1:0]   period_q,   period_nxt;
  logic [CW-1:0]   count_q,    count_nxt;
  logic            guard_q,    guard_nxt;
  logic            drain_q,    drain_nxt;
  logic            ret_run_q,  ret_run_nxt;
  logic            stop_lat_q, stop_lat_nxt;
  logic [CW-1:0]   trig_cnt_nxt;
  logic            miss_nxt;
  logic [CH_NUM-1:0] ch_en_nxt;
  logic            done_nxt;
  logic            busy_nxt;
  logic            trig_nxt;
  logic            upd_nxt;
  logic            pend_nxt;
  logic            all_ready;
  logic            guard_ok;
  logic            last_trig;
  logic            copy_en;

  cfg_t shad_q [CH_NUM];
  cfg_t act_q  [CH_NUM];

  assign all_ready = &ch_ready;
  assign guard_ok  = ~guard_q;
  assign last_trig = (count_q != CW'(0)) && ((trig_cnt + CW'(1)) == count_q);
  assign copy_en   = (state_nxt == S_UPD_COPY);

  // Next-state and registered-output logic
  always_comb begin
    state_nxt    = state_q;
    per_cnt_nxt  = per_cnt_q;
    period_nxt   = period_q;
    count_nxt    = count_q;
    guard_nxt    = 1'b0;
    drain_nxt    = drain_q;
    ret_run_nxt  = ret_run_q;
    stop_lat_nxt = stop_lat_q;
    trig_cnt_nxt = trig_cnt;
    miss_nxt     = miss;
    ch_en_nxt    = ch_en;
    done_nxt     = 1'b0;

    // Period counter keeps running through in-RUN updates so cadence is preserved
    if (state_q == S_RUN || ((state_q == S_UPD_COPY || state_q == S_UPD_STRB) && ret_run_q)) begin
      per_cnt_nxt = ch_trig ? (clamp_period(period_q) - CW'(1)) : (per_cnt_q - CW'(1));
    end

    if (state_q == S_RUN && ch_trig) begin
      trig_cnt_nxt = trig_cnt + CW'(1);
      guard_nxt    = 1'b1;
      if (guard_ok && !all_ready) miss_nxt = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          state_nxt    = S_RUN;
          per_cnt_nxt  = clamp_period(cfg_period) - CW'(1);
          period_nxt   = cfg_period;
          count_nxt    = cfg_count;
          trig_cnt_nxt = CW'(0);
          miss_nxt     = 1'b0;
          ch_en_nxt    = '1;
          guard_nxt    = 1'b0;
          stop_lat_nxt = 1'b0;
        end else if (commit_pend) begin
          state_nxt   = S_UPD_COPY;
          ret_run_nxt = 1'b0;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_nxt = S_IDLE;
          ch_en_nxt = '0;
          done_nxt  = 1'b1;
        end else if (ch_trig && last_trig) begin
          state_nxt = S_DRAIN;
          drain_nxt = 1'b1;
        end else if (commit_pend && guard_ok && all_ready && per_cnt_q >= CW'(3)) begin
          state_nxt    = S_UPD_COPY;
          ret_run_nxt  = 1'b1;
          stop_lat_nxt = 1'b0;
        end
      end
      S_UPD_COPY: begin
        state_nxt = S_UPD_STRB;
        if (ret_run_q && stop) begin
          ch_en_nxt    = '0;
          stop_lat_nxt = 1'b1;
        end
      end
      S_UPD_STRB: begin
        if (!ret_run_q) begin
          state_nxt = S_IDLE;
        end else if (stop || stop_lat_q) begin
          state_nxt    = S_IDLE;
          ch_en_nxt    = '0;
          done_nxt     = 1'b1;
          stop_lat_nxt = 1'b0;
        end else begin
          state_nxt = S_RUN;
        end
      end
      S_DRAIN: begin
        if (stop) begin
          state_nxt = S_IDLE;
          ch_en_nxt = '0;
          done_nxt  = 1'b1;
        end else if (drain_q) begin
          drain_nxt = 1'b0;
        end else if (all_ready) begin
          state_nxt = S_IDLE;
          ch_en_nxt = '0;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    trig_nxt = (state_nxt == S_RUN) && (per_cnt_nxt == CW'(0));
    upd_nxt  = (state_nxt == S_UPD_STRB);
    busy_nxt = (state_nxt != S_IDLE);
    pend_nxt = commit | (commit_pend & (state_nxt != S_UPD_COPY));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      per_cnt_q     <= CW'(0);
      period_q      <= DEFAULT_PERIOD;
      count_q       <= CW'(0);
      guard_q       <= 1'b0;
      drain_q       <= 1'b0;
      ret_run_q     <= 1'b0;
      stop_lat_q    <= 1'b0;
      trig_cnt      <= CW'(0);
      miss          <= 1'b0;
      ch_en         <= '0;
      done          <= 1'b0;
      busy          <= 1'b0;
      ch_trig       <= 1'b0;
      ch_cfg_update <= 1'b0;
      commit_pend   <= 1'b0;
    end else begin
      state_q       <= state_nxt;
      per_cnt_q     <= per_cnt_nxt;
      period_q      <= period_nxt;
      count_q       <= count_nxt;
      guard_q       <= guard_nxt;
      drain_q       <= drain_nxt;
      ret_run_q     <= ret_run_nxt;
      stop_lat_q    <= stop_lat_nxt;
      trig_cnt      <= trig_cnt_nxt;
      miss          <= miss_nxt;
      ch_en         <= ch_en_nxt;
      done          <= done_nxt;
      busy          <= busy_nxt;
      ch_trig       <= trig_nxt;
      ch_cfg_update <= upd_nxt;
      commit_pend   <= pend_nxt;
    end
  end

  // Shadow/active config; the copy sees shadow values from before any same-cycle write
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < CH_NUM; i++) begin
        shad_q[i] <= CFG_RST;
        act_q[i]  <= CFG_RST;
      end
    end else begin
      for (int unsigned i = 0; i < CH_NUM; i++) begin
        if (copy_en) act_q[i] <= shad_q[i];
        if (wr_en && wr_ch == 8'(i)) begin
          shad_q[i] <= '{typ: wr_type, hold: wr_hold, delay: wr_delay};
        end
      end
    end
  end

  for (genvar g = 0; g < CH_NUM; g++) begin : g_out
    assign ch_cfg_type [TW*g +: TW] = act_q[g].typ;
    assign ch_cfg_hold [CW*g +: CW] = act_q[g].hold;
    assign ch_cfg_delay[CW*g +: CW] = act_q[g].delay;
  end

endmodule

// File: doc/util_pulse_seq.md
# util_pulse_seq

Trigger scheduler and configuration sequencer for a bank of `CH_NUM` pulse-delay channels. It generates the shared periodic `trig` with a programmable period and burst length. It holds per-channel shadow configuration and applies commits to the channels only at safe points, when no pulse is in flight and no trigger is imminent. It sits between the register interface and the pulse-delay channel array and drives their `en`, `trig`, `cfg_update` and `cfg_*` inputs.

## Interface
- `CH_NUM`, 4: number of channels, 1..16.
- `DEFAULT_PERIOD`, 32'd1000: trigger period used when `cfg_period` has not yet been sampled.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous reset, active-high.
- `start`  in  1  one-cycle pulse; begin a burst. Ignored unless in IDLE.
- `stop`  in  1  one-cycle pulse; abort the burst.
- `cfg_period`  in  32  trigger period in clk cycles, sampled on an accepted `start`.
- `cfg_count`  in  32  triggers per burst; 0 = continuous. Sampled on `start`.
- `wr_en`  in  1  shadow write strobe.
- `wr_ch`  in  8  shadow channel index.
- `wr_type`  in  2  shadow `cfg_type` value.
- `wr_hold`  in  32  shadow `cfg_hold` value.
- `wr_delay`  in  32  shadow `cfg_delay` value.
- `commit`  in  1  request to apply shadow to active.
- `commit_pend`  out  1  commit requested, not yet applied.
- `busy`  out  1  state is not IDLE.
- `done`  out  1  one-cycle pulse at the end of a burst or stop.
- `trig_cnt`  out  32  triggers issued in the current burst.
- `miss`  out  1  sticky; a trigger was issued while some channel was not ready.
- `ch_ready`  in  CH_NUM  per-channel ready.
- `ch_en`  out  CH_NUM  per-channel enable.
- `ch_trig`  out  1  broadcast trigger.
- `ch_cfg_update`  out  1  broadcast config-update strobe.
- `ch_cfg_type`  out  2*CH_NUM  active config; channel i is bits [2i+1:2i].
- `ch_cfg_hold`  out  32*CH_NUM  active config; channel i is bits [32i+31:32i].
- `ch_cfg_delay`  out  32*CH_NUM  active config; channel i is bits [32i+31:32i].

## Operation
- **Reset values.** All outputs are 0 except the config outputs. Shadow and active config per channel reset to type 2'b00, hold 1, delay 0. Period register resets to `DEFAULT_PERIOD`, count register to 0.
- **Shadow writes.** `wr_en` writes shadow[`wr_ch`] in any state. If `wr_ch` >= `CH_NUM`, the write is ignored.
- **Commit.**
  - `commit` sets `commit_pend`.
  - An update is the two-cycle sequence UPD_COPY then UPD_STRB.
  - UPD_COPY: active <= shadow (values before any same-cycle write); `commit_pend` cleared.
  - UPD_STRB: `ch_cfg_update` = 1 for exactly one cycle.
  - A `commit` arriving during UPD_COPY or UPD_STRB leaves `commit_pend` = 1.
- **Period handling.** P = max(`cfg_period`, 2). N = `cfg_count`.
- **FSM states:** IDLE, RUN, UPD_COPY, UPD_STRB, DRAIN.
- **IDLE.**
  - `start` -> RUN: `per_cnt` = P-1, `trig_cnt` = 0, `miss` = 0, `ch_en` = all ones.
  - Otherwise, if `commit_pend` -> UPD_COPY, then UPD_STRB, then IDLE.
  - `start` takes priority over a pending commit.
- **RUN.**
  - `per_cnt` decrements every cycle, including during in-RUN updates. `ch_trig` = (`per_cnt` == 0), after which `per_cnt` reloads to P-1.
  - Each trigger increments `trig_cnt`, which wraps in continuous mode.
  - `miss` is set if a trigger issues while the guard has expired and any `ch_ready` bit is 0.
  - The guard expires 2 cycles after the previous trigger, because channel `ready` lags `trig` by 2 cycles.
  - Safe point: `commit_pend` && guard expired && `&ch_ready` && `per_cnt` >= 3. At a safe point -> UPD_COPY, UPD_STRB, back to RUN. `cfg_update` never coincides with `ch_trig`.
  - If N != 0 and the N-th trigger issues -> DRAIN.
- **DRAIN.** Wait 2 cycles, then wait for `&ch_ready`. Then `ch_en` = 0, `done` = 1, -> IDLE. No triggers and no updates are issued in DRAIN.
- **stop.**
  - In RUN, DRAIN or an in-RUN update: `ch_en` = 0 next cycle, `done` pulse, -> IDLE.
  - An update already in UPD_COPY completes its UPD_STRB first.
  - `stop` in IDLE has no effect.
- **Priority:** `rst` > `stop` > `start`. `start` outside IDLE is ignored. `commit_pend` survives `stop`.

## Timing
- Accepted `start` at cycle 0: triggers at cycles P, 2P, 3P, ...
- `busy` = 1 from cycle 1.
- `trig_cnt` updates the cycle after each trigger.
- Commit accepted in IDLE at cycle c: `commit_pend` high at c+1; new `ch_cfg_*` visible at c+2; `ch_cfg_update` high at c+3.
- Final burst trigger at cycle t: earliest `done` is at t+3; `ch_en` low in the same cycle as `done`.
- `rst` mid-update: `ch_cfg_update` is not asserted and `commit_pend` = 0. Active config returns to its defaults.

## Test plan
- P=5, N=3, channels held ready: `ch_trig` at cycles 5, 10, 15. `trig_cnt` = 3. `done` at cycle 18. `ch_en` = 0 and `busy` = 0 afterwards.
- `cfg_period` = 0, N=4: triggers every 2 cycles (cycles 2, 4, 6, 8). `miss` stays 0 with ideal ready.
- IDLE: write ch1 type 2'b10, hold 3, delay 2, then `commit` at cycle 10: `ch_cfg_hold[63:32]` = 3 at cycle 12, `ch_cfg_update` at cycle 13 only. Write with `wr_ch` = 9: no change.
- RUN with P=20 and channel models (hold 3, delay 2), `commit` 1 cycle after a trigger: update is deferred until `ch_ready` is all ones and the guard has expired. `cfg_update` never lands within 3 cycles of a trigger. Trigger cadence is unchanged.
- `stop` with `start` in the same cycle mid-RUN: `ch_en` = 0 next cycle, one `done` pulse, no further `ch_trig`, state IDLE. A `start` 1 cycle later restarts with `trig_cnt` = 0.
- `rst` asserted during UPD_COPY with a second commit pending: the next cycle shows all outputs at reset values, `commit_pend` = 0, and no `ch_cfg_update`.
